// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter state encoding, frame/byte widths and
// the 14-bit display value to 16-bit frame packing used by master and slave.
package spi_pkg;

   localparam int SPI_FRAME_BITS   = 16;
   localparam int SPI_BYTE_BITS    = 8;
   localparam int SPI_DATA_BITS    = 14;
   localparam int SPI_HI_DATA_BITS = SPI_DATA_BITS - SPI_BYTE_BITS;
   localparam int SPI_PAD_BITS     = SPI_BYTE_BITS - SPI_HI_DATA_BITS;
   localparam int SPI_BIT_CNT_W    = $clog2(SPI_FRAME_BITS);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SCLK_HI,
      SCLK_LO,
      TRAIL,
      DONE
   } spi_tx_state_e;

   // High byte carries the top data bits padded with zeros.
   function automatic logic [SPI_FRAME_BITS-1:0] spi_pack(input logic [SPI_DATA_BITS-1:0] data);
      return {{SPI_PAD_BITS{1'b0}}, data};
   endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: pulses tick every CLK_DIV cycles while en is high.
module spi_sclk_div #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Count is held at zero while disabled, so every enable rise starts a full period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_reg <= '0;
      else if (!en || cnt_reg == CNT_MAX)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign tick = en && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master sending a 14-bit value as a two-byte frame.
// Optional miso loop capture into rx_word when SPI_MISO_CAPTURE_EN is defined.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 50
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SPI_DATA_BITS-1:0]  tx_data,
   output logic                      busy,
   output logic                      done,
   output logic [SPI_FRAME_BITS-1:0] rx_word,
   output logic                      sclk,
   output logic                      mosi,
   input  logic                      miso,
   output logic                      SS
);

   localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_FRAME_BITS - 1);

   spi_tx_state_e             state_reg, state_next;
   logic [SPI_FRAME_BITS-1:0] shift_reg, shift_next;
   logic [SPI_BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic                      mosi_reg, mosi_next;
   logic                      ss_reg, sclk_reg, busy_reg, done_reg;
   logic [SPI_FRAME_BITS-1:0] frame_word;
   logic                      div_en, div_tick;

   assign frame_word = spi_pack(tx_data);
   assign div_en     = (state_reg != IDLE) && (state_reg != DONE);

   spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (div_en),
      .tick  (div_tick)
   );

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      mosi_next    = mosi_reg;
      case (state_reg)
         IDLE: if (start) begin
            state_next   = LEAD;
            shift_next   = frame_word;
            bit_cnt_next = '0;
            mosi_next    = frame_word[SPI_FRAME_BITS-1];
         end
         LEAD: if (div_tick) state_next = SCLK_HI;
         SCLK_HI: if (div_tick) begin
            state_next = SCLK_LO;
            shift_next = shift_reg << 1;
            mosi_next  = shift_reg[SPI_FRAME_BITS-2];
         end
         // bit_cnt_reg[3] doubles as the byte index within the frame.
         SCLK_LO: if (div_tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
               state_next = TRAIL;
            end else begin
               state_next   = SCLK_HI;
               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end
         TRAIL:   if (div_tick) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (state_next == IDLE || state_next == DONE)
         mosi_next = 1'b0;
   end

   // Pin drivers are registered from the next state so they change cleanly with the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         mosi_reg    <= 1'b0;
         ss_reg      <= 1'b1;
         sclk_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         mosi_reg    <= mosi_next;
         ss_reg      <= (state_next == IDLE) || (state_next == DONE);
         sclk_reg    <= (state_next == SCLK_HI);
         busy_reg    <= (state_next != IDLE);
         done_reg    <= (state_next == DONE);
      end
   end

   assign SS   = ss_reg;
   assign sclk = sclk_reg;
   assign mosi = mosi_reg;
   assign busy = busy_reg;
   assign done = done_reg;

`ifdef SPI_MISO_CAPTURE_EN
   logic [SPI_FRAME_BITS-1:0] rx_shift_reg, rx_word_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_shift_reg <= '0;
         rx_word_reg  <= '0;
      end else begin
         if (state_next == SCLK_HI && state_reg != SCLK_HI)
            rx_shift_reg <= {rx_shift_reg[SPI_FRAME_BITS-2:0], miso};
         if (state_next == DONE)
            rx_word_reg <= rx_shift_reg;
      end
   end

   assign rx_word = rx_word_reg;
`else
   logic unused_miso;
   assign unused_miso = miso;
   assign rx_word     = '0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: stimulus queues expected bytes/rx words,
// a negedge monitor acting as the mode-0 slave pops and compares them.
module tb_spi_master_tx;

   localparam int CLK_DIV = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [13:0] tx_data = '0;
   logic        busy, done, sclk, mosi, miso, SS;
   logic [15:0] rx_word;

   assign miso = mosi;

   spi_master_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_word (rx_word),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
      .SS      (SS)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int exp_done = 0;
   int done_cnt = 0;
   logic [7:0]  exp_byte_q[$];
   logic [15:0] exp_rx_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // ---------------- monitor / slave model ----------------
   logic [7:0] rx_byte = '0;
   int bit_n = 0, rise_n = 0, ss_low = 0, ss_high = 2;
   logic prev_ss = 1'b1, prev_sclk = 1'b0, busy_chk = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         bit_n = 0; rise_n = 0; ss_low = 0; ss_high = 2;
         prev_ss = 1'b1; prev_sclk = 1'b0; busy_chk = 1'b0;
      end else begin
         if (busy_chk) begin
            check("busy_after_done", busy, 0);
            check("done_width", done, 0);
            busy_chk = 1'b0;
         end
         if (!SS) begin
            if (prev_ss) begin
               check("ss_high_gap", ss_high >= 2, 1);
               check("busy_at_ss_fall", busy, 1);
               ss_low = 0; rise_n = 0; bit_n = 0;
            end
            ss_low++;
            if (sclk && !prev_sclk) begin
               rise_n++;
               if (rise_n == 1) check("first_sclk_delay", ss_low, CLK_DIV + 1);
               rx_byte = {rx_byte[6:0], mosi};
               bit_n++;
               if (bit_n == 8) begin
                  bit_n = 0;
                  if (exp_byte_q.size() == 0) begin
                     chk_cnt++;
                     $display("FAIL byte_unexpected: got %02h, expected none", rx_byte);
                  end else begin
                     check("byte", rx_byte, exp_byte_q.pop_front());
                  end
               end
            end
            ss_high = 0;
         end else begin
            if (!prev_ss) begin
               check("ss_low_cycles", ss_low, 34 * CLK_DIV);
               check("sclk_rises", rise_n, 16);
            end
            ss_high++;
         end
         if (done) begin
            done_cnt++;
            check("done_with_ss_high", SS, 1);
            if (exp_rx_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL done_unexpected: got rx_word %04h, expected no done", rx_word);
            end else begin
               check("rx_word", rx_word, exp_rx_q.pop_front());
            end
            busy_chk = 1'b1;
         end
         prev_ss = SS;
         prev_sclk = sclk;
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1);
      exp_byte_q.push_back(b0);
      exp_byte_q.push_back(b1);
`ifdef SPI_MISO_CAPTURE_EN
      exp_rx_q.push_back({b0, b1});
`else
      exp_rx_q.push_back(16'h0000);
`endif
      exp_done++;
   endtask

   task automatic send(input logic [13:0] d, input logic [7:0] b0, input logic [7:0] b1);
      expect_frame(b0, b1);
      @(posedge clk); #1;
      tx_data = d;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_frames(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (done_cnt >= exp_done && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk_cnt++;
         $display("FAIL %s_timeout: done count %0d, expected %0d", name, done_cnt, exp_done);
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic last_sclk;
      bit ok;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ss", SS, 1);
      check("reset_sclk", sclk, 0);
      check("reset_mosi", mosi, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rx_word", rx_word, 16'h0000);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      send(14'h1234, 8'h12, 8'h34); wait_frames("f1234");
      send(14'h3FFF, 8'h3F, 8'hFF); wait_frames("f3fff");
      send(14'h0000, 8'h00, 8'h00); wait_frames("f0000");

      // start pulsed mid-frame must be ignored
      send(14'h0ABC, 8'h0A, 8'hBC);
      repeat (20) @(posedge clk);
      #1;
      tx_data = 14'h1111;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      wait_frames("fmid");

      // start held high: three back-to-back frames
      for (int i = 0; i < 3; i++) expect_frame(8'h01, 8'h55);
      @(posedge clk); #1;
      tx_data = 14'h0155;
      start   = 1'b1;
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (done) n++;
         if (n == 3) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!ok) begin
         chk_cnt++;
         $display("FAIL held_start_timeout: done pulses %0d, expected 3", n);
      end
      wait_frames("fheld");

      // reset during bit 9 of a 0x3C,0x5A frame: only the first byte arrives
      exp_byte_q.push_back(8'h3C);
      @(posedge clk); #1;
      tx_data = 14'h3C5A;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      n = 0;
      last_sclk = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (sclk && !last_sclk) n++;
         last_sclk = sclk;
         if (n == 10) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk_cnt++;
         $display("FAIL abort_timeout: sclk rises %0d, expected 10", n);
      end
      reset = 1'b0;
      #1;
      check("abort_ss", SS, 1);
      check("abort_sclk", sclk, 0);
      check("abort_mosi", mosi, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_rx_word", rx_word, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);

      send(14'h2001, 8'h20, 8'h01); wait_frames("f2001");
      send(14'h2A5C, 8'h2A, 8'h5C); wait_frames("f2a5c");

      check("bytes_outstanding", exp_byte_q.size(), 0);
      check("rx_outstanding", exp_rx_q.size(), 0);
      check("done_pulses", done_cnt, exp_done);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI mode-0 master transmitter that sends one 14-bit display value to the FND-driving SPI slave as a two-byte frame. On a `start` request it drives SS low, shifts out the high byte then the low byte MSB-first on `mosi`, returns SS high, and pulses `done`. It sits on the master board between the counter/control logic and the SPI pins.

## Interface
- `CLK_DIV`, 50, `clk` cycles per SCLK half-period (sclk = clk / (2*CLK_DIV)); legal range ≥ 2
- `clk`  input  1  system clock; all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset)
- `start`  input  1  frame request, sampled only in IDLE
- `tx_data`  input  14  value to send, latched when `start` is accepted
- `busy`  output  1  frame in progress
- `done`  output  1  one-cycle pulse at frame end
- `rx_word`  output  16  bytes captured from `miso` (see Configuration)
- `sclk`  output  1  SPI clock, idle low
- `mosi`  output  1  SPI data out
- `miso`  input  1  SPI data in
- `SS`  output  1  slave select, active-low

## Operation
- Frame: byte0 = {2'b00, tx_data[13:8]}, byte1 = tx_data[7:0]; MSB first; CPOL=0, CPHA=0.
- States: IDLE → LEAD → SCLK_HI ⇄ SCLK_LO → TRAIL → DONE → IDLE.
- IDLE: SS=1, sclk=0. `start`=1 latches `tx_data` into a 16-bit shift register; next state LEAD.
- LEAD: SS=0, `mosi` = bit 15 of shift register; lasts CLK_DIV cycles.
- SCLK_HI: sclk=1 for CLK_DIV cycles; the slave samples at the rising edge. With capture enabled, `miso` is sampled on entry.
- SCLK_LO: sclk=0 for CLK_DIV cycles; on entry the shift register shifts left and `mosi` presents the next bit. After the 16th low phase → TRAIL, otherwise → SCLK_HI.
- Counters: divider 0..CLK_DIV-1; bit counter 0..15 (bit[3] = byte index).
- TRAIL: SS=0, sclk=0 for CLK_DIV cycles.
- DONE: SS=1, `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE).
- `start` outside IDLE is ignored; no queuing.
- `start` held high continuously: a new frame begins every frame period. SS is high for at least 2 cycles between frames (DONE + IDLE).
- `reset` asserted mid-frame: all outputs go to reset values immediately, the frame is dropped, and no `done` pulse is produced.

## Timing
- Reset values: SS=1, sclk=0, mosi=0, busy=0, done=0, rx_word=0.
- `start` accepted at edge t0.
  - SS falls and `busy` rises after edge t0 (registered outputs).
  - First sclk rise occurs CLK_DIV cycles after the SS fall.
  - SS low duration = 34·CLK_DIV cycles exactly.
  - `done` is high in the cycle SS returns high; `busy` falls the cycle after.
- `mosi` is stable for ≥ CLK_DIV cycles before each rising sclk edge.
- All SPI outputs are registered; no combinational path from inputs to pins.

## Configuration
- `SPI_MISO_CAPTURE_EN` defined:
  - `miso` is shifted into a 16-bit receive register at each SCLK_HI entry.
  - `rx_word` updates with the full 16 bits in the DONE cycle and holds until the next DONE or reset.
- Not defined:
  - `rx_word` is tied to 16'h0000 and no receive register is built.
  - `miso` is unused.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_tx_state_e`
  - `SPI_FRAME_BITS` = 16
  - `SPI_BYTE_BITS` = 8
  - byte-packing width constants reused by the slave's control unit
- One sub-module, `spi_sclk_div`: half-period tick generator that emits a pulse every CLK_DIV cycles while enabled and resets its count on enable rise.
- The FSM, shift registers and bit counter live in `spi_master_tx`.

## Test plan
- CLK_DIV=2, `tx_data`=14'h1234, mode-0 slave model → bytes 0x12, 0x34 received; SS low exactly 68 cycles; one `done` pulse; `busy` falls the cycle after `done`.
- `tx_data`=14'h3FFF → bytes 0x3F, 0xFF; `tx_data`=14'h0000 → 0x00, 0x00 with `mosi` low throughout.
- Start frame with 14'h0ABC, pulse `start` with 14'h1111 at mid-frame → only 0x0A, 0xBC sent; single `done`; 14'h1111 never appears.
- `start` held high for 3 frames with 14'h0155 → three identical frames, each separated by ≥ 2 cycles of SS high, and 3 `done` pulses.
- `reset`=0 during bit 9 → SS=1, sclk=0, mosi=0 in the same cycle, no `done`. After release, a 14'h2001 frame transmits 0x20, 0x01 correctly.
- With `SPI_MISO_CAPTURE_EN`, `miso` looped to `mosi`, `tx_data`=14'h2A5C → `rx_word`=16'h2A5C in the DONE cycle. Without the macro, `rx_word` stays 16'h0000.
